mem_rr_arbiter: RTL and testbench

//  Shares the single soc read-memory port (mem_valid/mem_ready/mem_addr/mem_rdata) among NREQ

---
 rtl/millcore_bus_pkg.sv | 11 +
 rtl/mem_rr_arbiter_rr_pick.sv | 31 +++
 rtl/mem_rr_arbiter.sv | 85 ++++++++
 tb/tb_mem_rr_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/millcore_bus_pkg.sv
// Shared definitions for the soc read-port arbiter: FSM encoding, abort data and
// default watchdog length.
package millcore_bus_pkg;
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned ERR_RDATA   = 0;
  localparam int          DEF_TIMEOUT = 16;
endpackage

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping,
// so the most recently served index always has the lowest priority.
module rr_pick
  import millcore_bus_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   gnt,
  output logic            any
);
  always_comb begin
    int best;
    int d;
    best = NREQ;
    d    = 0;
    gnt  = '0;
    any  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      // distance from last+1 going forward; zero is the highest priority
      d = (i + NREQ - 1 - int'(last)) % NREQ;
      if (req[i] && d < best) begin
        best = d;
        gnt  = IW'(i);
        any  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin sharing of the single soc read-memory port among NREQ masters,
// one transaction in flight, with a watchdog that aborts a silent memory.
module mem_rr_arbiter
  import millcore_bus_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    req_ready,
  output logic [DW-1:0]      req_rdata,
  output logic               req_err,
  output logic               mem_valid,
  output logic [AW-1:0]      mem_addr,
  input  logic               mem_ready,
  input  logic [DW-1:0]      mem_rdata
);
  localparam int IW = $clog2(NREQ);
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] WD_LAST = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;
  localparam logic [WW-1:0] WD_MAX  = (TIMEOUT > 0) ? WW'(TIMEOUT) : '0;

  arb_state_e    state;
  logic [IW-1:0] last;
  logic [WW-1:0] wdog;
  logic [IW-1:0] pick_g;
  logic          pick_any;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req  (req_valid),
    .last (last),
    .gnt  (pick_g),
    .any  (pick_any)
  );

  // 'last' doubles as the current grant: it is only updated when a grant is made
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      last      <= IW'(NREQ - 1);
      wdog      <= '0;
      req_ready <= '0;
      req_rdata <= '0;
      req_err   <= 1'b0;
    end else begin
      req_ready <= '0;
      req_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state     <= ST_BUSY;
            mem_valid <= 1'b1;
            mem_addr  <= req_addr[pick_g*AW +: AW];
            last      <= pick_g;
            wdog      <= '0;
          end
        end
        ST_BUSY: begin
          if (mem_ready) begin
            req_ready <= NREQ'(1) << last;
            req_rdata <= mem_rdata;
            mem_valid <= 1'b0;
            state     <= ST_IDLE;
          end else if (TIMEOUT != 0 && wdog == WD_LAST) begin
            req_ready <= NREQ'(1) << last;
            req_err   <= 1'b1;
            req_rdata <= DW'(ERR_RDATA);
            mem_valid <= 1'b0;
            state     <= ST_IDLE;
          end else if (wdog != WD_MAX) begin
            wdog <= wdog + WW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed + randomized bench for mem_rr_arbiter against a transaction-level model.
module tb_mem_rr_arbiter;
  localparam int NREQ = 2, AW = 32, DW = 32, TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid, req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [DW-1:0]      req_rdata, mem_rdata;
  logic               req_err, mem_valid, mem_ready, mem_ready_m, late;
  logic [AW-1:0]      mem_addr;

  // NREQ=3 instance with the watchdog disabled
  logic [2:0]  req_valid3, req_ready3;
  logic [95:0] req_addr3;
  logic [31:0] req_rdata3, mem_addr3, mem_rdata3;
  logic        req_err3, mem_valid3, mem_ready3;

  int checks = 0, errors = 0;
  int mem_delay = 1, mcnt, served3 = 0;
  bit mem_en = 1'b1;

  function automatic logic [31:0] memf(logic [31:0] a);
    return a ^ 32'hA5A5A5A5;
  endfunction

  function automatic logic [31:0] rnd_addr();
    return $urandom() & 32'hFFFF_FFFC;
  endfunction

  mem_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .req_rdata(req_rdata), .req_err(req_err),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  mem_rr_arbiter #(.NREQ(3), .AW(32), .DW(32), .TIMEOUT(0)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_addr(req_addr3),
    .req_ready(req_ready3), .req_rdata(req_rdata3), .req_err(req_err3),
    .mem_valid(mem_valid3), .mem_addr(mem_addr3), .mem_ready(mem_ready3), .mem_rdata(mem_rdata3)
  );

  // memory: answers mem_delay cycles after first seeing mem_valid (when enabled)
  assign mem_ready  = mem_ready_m | late;
  assign mem_rdata  = memf(mem_addr);
  assign mem_rdata3 = memf(mem_addr3);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_ready_m <= 1'b0;
      mcnt        <= 0;
    end else if (!mem_valid || mem_ready_m) begin
      mem_ready_m <= 1'b0;
      mcnt        <= 0;
    end else begin
      mem_ready_m <= mem_en && (mcnt == mem_delay - 1);
      mcnt        <= mcnt + 1;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) mem_ready3 <= 1'b0;
    else      mem_ready3 <= mem_valid3 && !mem_ready3;
  end

  // reference model: one open transaction with an age in cycles
  bit              m_act;
  int              m_own, m_age, m_last;
  logic [AW-1:0]   m_addr;
  logic            e_mv, e_err;
  logic [NREQ-1:0] e_rdy;
  logic [DW-1:0]   e_rd;
  logic [AW-1:0]   next_addr [NREQ];
  bit              reissue [NREQ];

  task automatic model_reset();
    m_act = 0; m_own = 0; m_age = 0; m_last = NREQ - 1; m_addr = '0;
    e_mv = 0; e_err = 0; e_rdy = '0; e_rd = '0;
  endtask

  task automatic model_step(input logic [NREQ-1:0] rv, input logic [NREQ*AW-1:0] ra,
                            input logic mr);
    bit found;
    e_rdy = '0;
    e_err = 1'b0;
    if (m_act) begin
      m_age++;
      if (mr) begin
        e_rdy[m_own] = 1'b1; e_rd = memf(m_addr); m_act = 0;
      end else if (TO != 0 && m_age == TO) begin
        e_rdy[m_own] = 1'b1; e_err = 1'b1; e_rd = '0; m_act = 0;
      end
    end else begin
      found = 0;
      for (int k = 1; k <= NREQ; k++) begin
        int i;
        i = (m_last + k) % NREQ;
        if (!found && rv[i]) begin
          found = 1; m_act = 1; m_own = i; m_last = i; m_age = 0;
          m_addr = ra[i*AW +: AW];
        end
      end
    end
    e_mv = m_act;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cmp(input string tag);
    chk({tag, ".mem_valid"}, 64'(mem_valid), 64'(e_mv));
    if (e_mv) chk({tag, ".mem_addr"}, 64'(mem_addr), 64'(m_addr));
    chk({tag, ".req_ready"}, 64'(req_ready), 64'(e_rdy));
    chk({tag, ".req_err"}, 64'(req_err), 64'(e_err));
    if (e_rdy != '0) chk({tag, ".req_rdata"}, 64'(req_rdata), 64'(e_rd));
    chk({tag, ".onehot3"}, 64'($onehot0(req_ready3)), 64'(1));
    if (req_ready3 != '0) begin
      served3++;
      chk({tag, ".rdy3"}, 64'(req_ready3), 64'(3'b100));
      chk({tag, ".rdata3"}, 64'(req_rdata3), 64'(memf(32'h40)));
    end
    if (mem_valid3) chk({tag, ".addr3"}, 64'(mem_addr3), 64'(32'h40));
  endtask

  // one clock: sample inputs as the DUT sees them, advance model, compare, update masters
  task automatic step(input string tag);
    logic [NREQ-1:0]    rv;
    logic [NREQ*AW-1:0] ra;
    logic               mr;
    rv = req_valid; ra = req_addr; mr = mem_ready;
    @(posedge clk);
    model_step(rv, ra, mr);
    #1;
    cmp(tag);
    for (int i = 0; i < NREQ; i++) begin
      if (e_rdy[i]) begin
        if (reissue[i]) req_addr[i*AW +: AW] = next_addr[i];
        else req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic run_until_ready(input string tag, output int n);
    n = -1;
    for (int k = 1; k <= 60; k++) begin
      step(tag);
      if (req_ready != '0) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; req_valid = '0; req_valid3 = '0; late = 1'b0;
    for (int i = 0; i < NREQ; i++) reissue[i] = 0;
    #1;
    chk("reset.async_mem_valid", 64'(mem_valid), 64'(0));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp("reset");
    chk("reset.req_rdata", 64'(req_rdata), 64'(0));
    chk("reset.mem_addr", 64'(mem_addr), 64'(0));
    rst = 1'b1;
  endtask

  initial begin
    int n, served;
    int order[$];
    rst = 1'b1; req_valid = '0; req_addr = '0; late = 1'b0;
    req_valid3 = '0; req_addr3 = '0;
    for (int i = 0; i < NREQ; i++) begin reissue[i] = 0; next_addr[i] = '0; end
    #2;
    do_reset();

    // single request, 1-cycle memory
    req_addr[0 +: AW] = 32'h10; req_valid = 2'b01;
    run_until_ready("t1", n);
    chk("t1.latency", 64'(n), 64'(3));
    chk("t1.ready", 64'(req_ready), 64'(2'b01));
    chk("t1.rdata", 64'(req_rdata), 64'(32'hA5A5A5B5));
    chk("t1.err", 64'(req_err), 64'(0));

    // two continuous requesters alternate
    do_reset();
    req_addr[0 +: AW] = 32'h4; req_addr[AW +: AW] = 32'h8;
    next_addr[0] = 32'h4; next_addr[1] = 32'h8; reissue[0] = 1; reissue[1] = 1;
    req_valid = 2'b11;
    for (int k = 0; k < 12; k++) begin
      step("t2");
      if (req_ready == 2'b01) order.push_back(0);
      else if (req_ready == 2'b10) order.push_back(1);
    end
    chk("t2.count", 64'(order.size()), 64'(4));
    foreach (order[k]) chk("t2.order", 64'(order[k]), 64'(k % 2));
    reissue[0] = 0; reissue[1] = 0; req_valid = '0;
    step("t2.drain");

    // memory silent: watchdog abort, then a stray late reply
    mem_en = 1'b0;
    req_addr[0 +: AW] = 32'h20; req_valid = 2'b01;
    run_until_ready("t3", n);
    chk("t3.latency", 64'(n), 64'(17));
    chk("t3.err", 64'(req_err), 64'(1));
    chk("t3.rdata", 64'(req_rdata), 64'(0));
    step("t3.after");
    chk("t3.mem_valid_low", 64'(mem_valid), 64'(0));
    late = 1'b1;
    step("t3.late");
    late = 1'b0;
    step("t3.late_after");
    chk("t3.no_ready", 64'(req_ready), 64'(0));
    mem_en = 1'b1;

    // reset while busy; fresh priority afterwards
    req_addr[0 +: AW] = 32'h50; req_valid = 2'b01;
    step("t4.grant");
    chk("t4.busy", 64'(mem_valid), 64'(1));
    do_reset();
    req_addr[AW +: AW] = 32'h60; req_valid = 2'b10;
    step("t4.req1");
    chk("t4.req1_addr", 64'(mem_addr), 64'(32'h60));
    run_until_ready("t4.req1_done", n);
    chk("t4.req1_lat", 64'(n), 64'(2));
    do_reset();
    req_addr[0 +: AW] = 32'h70; req_addr[AW +: AW] = 32'h74; req_valid = 2'b11;
    step("t4.both");
    chk("t4.req0_wins", 64'(mem_addr), 64'(32'h70));
    for (int k = 0; k < 20 && req_valid != '0; k++) step("t4.drain");
    chk("t4.drained", 64'(req_valid), 64'(0));

    // reply on the final watchdog cycle completes normally
    mem_delay = 15;
    req_addr[AW +: AW] = 32'h30; req_valid = 2'b10;
    run_until_ready("t5", n);
    chk("t5.latency", 64'(n), 64'(17));
    chk("t5.err", 64'(req_err), 64'(0));
    chk("t5.rdata", 64'(req_rdata), 64'(memf(32'h30)));
    mem_delay = 1;

    // NREQ=3, only requester 2, served every 3 cycles
    served3 = 0;
    req_addr3[64 +: 32] = 32'h40; req_valid3 = 3'b100;
    repeat (30) step("t6");
    chk("t6.served", 64'(served3), 64'(10));
    req_valid3 = '0;
    repeat (3) step("t6.drain");

    // randomized traffic, delays spanning both sides of the watchdog
    served = 0;
    for (int c = 0; c < 400; c++) begin
      if (!mem_valid) mem_delay = $urandom_range(1, 18);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1; req_addr[i*AW +: AW] = rnd_addr();
        end else if (req_valid[i] && !(m_act && m_own == i) && $urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
        reissue[i] = 1'($urandom_range(0, 1));
        next_addr[i] = rnd_addr();
      end
      step("rand");
      if (req_ready != '0) served++;
    end
    checks++;
    assert (served > 20)
    else begin
      errors++;
      $error("FAIL rand.activity: got %0d completions expected more than 20", served);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
